// File: rtl/sqrt_result_checker.sv
// Result checker for the Sqrt2 datapath: squares the root with a shift-add
// multiplier and verifies root^2 <= radicand < (root+1)^2.
module sqrt_result_checker #(
    parameter int W  = 15,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    radicand,
    input  logic [W-1:0]    root,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_pass,
    output logic [2*W-1:0]  res_square,
    output logic [CW-1:0]   pass_cnt,
    output logic [CW-1:0]   fail_cnt,
    output logic            busy
);

    localparam int NW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    rad_q, rad_d;
    logic [W-1:0]    root_q, root_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic            pass_q, pass_d;
    logic [2*W-1:0]  square_q, square_d;
    logic [CW-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CW-1:0]   fail_cnt_q, fail_cnt_d;

    logic            lo_ok, hi_ok, chk_pass;
    logic [2*W:0]    hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rad_q      <= '0;
            root_q     <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            pass_q     <= 1'b0;
            square_q   <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rad_q      <= rad_d;
            root_q     <= root_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            pass_q     <= pass_d;
            square_q   <= square_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = MUL;
            MUL:  if (cnt_q == NW'(W - 1)) state_d = CMP;
            CMP:  state_d = DONE;
            DONE: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // hi is one bit wider than the square so (root+1)^2 never truncates
    always_comb begin
        hi = {1'b0, acc_q}
           + {{W{1'b0}}, root_q, 1'b0}
           + {{(2*W){1'b0}}, 1'b1};
        lo_ok    = acc_q <= {{W{1'b0}}, rad_q};
        hi_ok    = {{(W+1){1'b0}}, rad_q} < hi;
        chk_pass = lo_ok & hi_ok;
    end

    always_comb begin
        rad_d      = rad_q;
        root_d     = root_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        square_d   = square_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rad_d    = radicand;
                    root_d   = root;
                    acc_d    = '0;
                    mcand_d  = {{W{1'b0}}, root};
                    mplier_d = root;
                    cnt_d    = '0;
                end
            end
            MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end
            CMP: begin
                pass_d   = chk_pass;
                square_d = acc_q;
                if (chk_pass) begin
                    if (!(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + 1'b1;
                end else begin
                    if (!(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + 1'b1;
                end
            end
            DONE: ;
            default: ;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        res_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
        res_pass   = pass_q;
        res_square = square_q;
        pass_cnt   = pass_cnt_q;
        fail_cnt   = fail_cnt_q;
    end

endmodule

// File: tb/tb_sqrt_result_checker.sv
// Directed bench for sqrt_result_checker: vector table, backpressure,
// mid-multiply reset and counter saturation on a narrow-counter instance.
module tb_sqrt_result_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        res_ready;
    logic [14:0] radicand;
    logic [14:0] root;
    logic        in_ready, res_valid, res_pass, busy;
    logic [29:0] res_square;
    logic [15:0] pass_cnt, fail_cnt;

    logic        in_ready2, res_valid2, res_pass2, busy2;
    logic [29:0] res_square2;
    logic [3:0]  pass_cnt2, fail_cnt2;

    int total = 0;
    int bad   = 0;
    int exp_p = 0;
    int exp_f = 0;

    always #5 clk = ~clk;

    sqrt_result_checker #(.W(15), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .radicand(radicand), .root(root),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pass(res_pass), .res_square(res_square),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
    );

    sqrt_result_checker #(.W(15), .CW(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready2),
        .radicand(radicand), .root(root),
        .res_valid(res_valid2), .res_ready(res_ready),
        .res_pass(res_pass2), .res_square(res_square2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .busy(busy2)
    );

    typedef struct {
        logic [14:0] rad;
        logic [14:0] rt;
        logic        pass;
        logic [29:0] sq;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [14:0] r, input logic [14:0] q);
        int n = 0;
        @(negedge clk);
        radicand = r;
        root     = q;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // n counts edges with the acceptance edge as 1
    task automatic wait_res(output int n);
        n = 1;
        while (!res_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("res_timeout", res_valid, 1);
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic run_check(input logic [14:0] r, input logic [14:0] q,
                             output logic p, output logic [29:0] sq,
                             output int n);
        accept(r, q);
        wait_res(n);
        p  = res_pass;
        sq = res_square;
        release_res();
    endtask

    initial begin
        logic        p;
        logic [29:0] sq;
        int          n;
        logic        hp;
        logic [29:0] hsq;

        vecs[0] = '{15'h0010, 15'h0004, 1'b1, 30'h00000010};
        vecs[1] = '{15'h0019, 15'h0004, 1'b0, 30'h00000010};
        vecs[2] = '{15'h0018, 15'h0004, 1'b1, 30'h00000010};
        vecs[3] = '{15'h7FFF, 15'h00B5, 1'b1, 30'h00007FF9};
        vecs[4] = '{15'h7FFF, 15'h7FFF, 1'b0, 30'h3FFF0001};
        vecs[5] = '{15'h0000, 15'h0000, 1'b1, 30'h00000000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        radicand  = '0;
        root      = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_pass", res_pass, 0);
        chk("rst_res_square", res_square, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_check(vecs[i].rad, vecs[i].rt, p, sq, n);
            if (vecs[i].pass) exp_p++;
            else exp_f++;
            chk($sformatf("v%0d_latency", i), n, 17);
            chk($sformatf("v%0d_pass", i), p, vecs[i].pass);
            chk($sformatf("v%0d_square", i), sq, vecs[i].sq);
            chk($sformatf("v%0d_pass_cnt", i), pass_cnt, exp_p);
            chk($sformatf("v%0d_fail_cnt", i), fail_cnt, exp_f);
            chk($sformatf("v%0d_idle", i), in_ready, 1);
            chk($sformatf("v%0d_held_pass", i), res_pass, vecs[i].pass);
        end

        // backpressure: 48 with root 6 passes, pending pair 36/6 passes
        accept(15'h0030, 15'h0006);
        wait_res(n);
        exp_p++;
        hp  = res_pass;
        hsq = res_square;
        chk("bp_first_pass", hp, 1);
        chk("bp_first_square", hsq, 36);
        radicand = 15'h0024;
        root     = 15'h0006;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_pass_stable", res_pass, hp);
            chk("bp_square_stable", res_square, hsq);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_pass_cnt", pass_cnt, exp_p);
            chk("bp_fail_cnt", fail_cnt, exp_f);
        end
        release_res();
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_valid", res_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_captured_busy", busy, 1);
        wait_res(n);
        exp_p++;
        chk("bp_second_latency", n, 17);
        chk("bp_second_pass", res_pass, 1);
        chk("bp_second_square", res_square, 36);
        chk("bp_second_cnt", pass_cnt, exp_p);
        release_res();

        // reset during the multiply
        accept(15'h0019, 15'h0004);
        repeat (3) @(negedge clk);
        chk("mr_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_busy", busy, 0);
        chk("mr_res_valid", res_valid, 0);
        chk("mr_pass_cnt", pass_cnt, 0);
        chk("mr_fail_cnt", fail_cnt, 0);
        chk("mr_square", res_square, 0);
        reset = 1'b0;
        exp_p = 0;
        exp_f = 0;
        run_check(15'h0010, 15'h0004, p, sq, n);
        exp_p++;
        chk("mr_after_latency", n, 17);
        chk("mr_after_pass", p, 1);
        chk("mr_after_square", sq, 16);
        chk("mr_after_cnt", pass_cnt, exp_p);

        // saturation on the 4-bit-counter instance
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            run_check(15'h0010, 15'h0004, p, sq, n);
            if (i == 14) chk("sat_reach_f", pass_cnt2, 4'hF);
        end
        chk("sat_pass_cnt", pass_cnt2, 4'hF);
        chk("sat_fail_cnt", fail_cnt2, 0);
        chk("sat_wide_pass_cnt", pass_cnt, 17);
        chk("sat_wide_fail_cnt", fail_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
